// File: rtl/hash_table_pkg.sv
// Shared hash-table definitions used by the table initializer, the insert and
// delete engines and the empty-pointer free list.
package hash_table;

    // Width of a data-table pointer; the data table holds 2**TABLE_ADDR_WIDTH rows.
    localparam int TABLE_ADDR_WIDTH = 8;

endpackage : hash_table

// File: rtl/empty_ptr_ram.sv
// Simple dual-port RAM for the free-pointer list: one write port, one read
// port, read address registered so data appears exactly one cycle after rd_en.
module empty_ptr_ram
    import hash_table::*;
#(
    parameter int A_WIDTH = TABLE_ADDR_WIDTH
) (
    input  logic               clk_i,
    input  logic               wr_en,
    input  logic [A_WIDTH-1:0] wr_addr,
    input  logic [A_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    input  logic [A_WIDTH-1:0] rd_addr,
    output logic [A_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** A_WIDTH;

    logic [A_WIDTH-1:0] mem [DEPTH];
    logic [A_WIDTH-1:0] rd_addr_q;

    // Write port and read-address register.
    // NOTE: the array has no reset on purpose; a reset would turn the block RAM
    // into flops. Contents are meaningless until written, and the control logic
    // only ever reads locations it has written since the last clear.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_addr_q <= rd_addr;
        end
    end

    // Read data follows the registered address; no extra output stage.
    assign rd_data = mem[rd_addr_q];

endmodule : empty_ptr_ram

// File: rtl/empty_ptr_storage.sv
// Free list of data-table pointers. Pointers from the initializer and the
// delete logic are queued in a RAM FIFO and presented one at a time to the
// insert engine through a show-ahead output register (val/ack handshake).
// The output register can be loaded straight from the add port when nothing
// is queued, so an empty free list returns a new pointer with one cycle latency.
module empty_ptr_storage
    import hash_table::*;
#(
    parameter int A_WIDTH = TABLE_ADDR_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               srst_i,

    input  logic [A_WIDTH-1:0] add_empty_ptr_i,
    input  logic               add_empty_ptr_en_i,

    output logic [A_WIDTH-1:0] next_empty_ptr_o,
    output logic               next_empty_ptr_val_o,
    input  logic               next_empty_ptr_rd_ack_i,

    output logic [A_WIDTH:0]   used_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    localparam int unsigned      DEPTH    = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0] CAPACITY = (A_WIDTH + 1)'(DEPTH);
    localparam logic [A_WIDTH:0] CNT_ONE  = (A_WIDTH + 1)'(1);
    localparam logic [A_WIDTH-1:0] PTR_ONE = A_WIDTH'(1);

    // RAM-side state
    logic [A_WIDTH-1:0] wr_ptr;
    logic [A_WIDTH-1:0] rd_ptr;
    logic [A_WIDTH:0]   ram_cnt;
    logic               rd_inflight;
    logic [A_WIDTH-1:0] ram_rd_data;

    // Output register and bookkeeping
    logic [A_WIDTH-1:0] out_ptr;
    logic               out_val;
    logic [A_WIDTH:0]   used;
    logic               overflow;
    logic               underflow;

    // Per-cycle decisions
    logic clear;
    logic ack_valid;
    logic out_free;
    logic ram_empty;
    logic full;
    logic add_accept;
    logic add_drop;
    logic bypass;
    logic ram_wr;
    logic ram_rd;

    // Decide what happens to this cycle's add and ack, and whether to refill.
    // NOTE: every signal gets a default at the top of the block so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        clear      = 1'b0;
        ack_valid  = 1'b0;
        out_free   = 1'b0;
        ram_empty  = 1'b0;
        full       = 1'b0;
        add_accept = 1'b0;
        add_drop   = 1'b0;
        bypass     = 1'b0;
        ram_wr     = 1'b0;
        ram_rd     = 1'b0;

        // A clear (reset or initializer pulse) overrides add and ack.
        clear     = !rst_n_i || srst_i;
        ack_valid = next_empty_ptr_rd_ack_i && out_val && !clear;
        out_free  = !out_val || ack_valid;
        ram_empty = (ram_cnt == '0);
        full      = (used == CAPACITY);

        // When full, an add is only taken if a pointer leaves in the same cycle.
        add_accept = add_empty_ptr_en_i && !clear && (!full || ack_valid);
        add_drop   = add_empty_ptr_en_i && !clear && full && !ack_valid;

        // Nothing queued ahead of this pointer: hand it straight to the output.
        bypass = add_accept && ram_empty && !rd_inflight && out_free;
        ram_wr = add_accept && !bypass;

        // Refill decision looks at the RAM before this cycle's write, so a
        // read is never issued at the address being written.
        ram_rd = !clear && out_free && !ram_empty && !rd_inflight;
    end

    empty_ptr_ram #(
        .A_WIDTH (A_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .wr_en   (ram_wr),
        .wr_addr (wr_ptr),
        .wr_data (add_empty_ptr_i),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    // RAM pointers, RAM occupancy and the read-in-flight flag.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
        end else begin
            if (ram_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({ram_wr, ram_rd})
                2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
                2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
                default: ram_cnt <= ram_cnt;
            endcase
            rd_inflight <= ram_rd;
        end
    end

    // Output register: loaded by a completing RAM read or by a bypass add,
    // emptied when the consumer acks and nothing replaces it.
    always_ff @(posedge clk_i) begin
        if (clear) begin
            out_ptr <= '0;
            out_val <= 1'b0;
        end else if (rd_inflight) begin
            out_ptr <= ram_rd_data;
            out_val <= 1'b1;
        end else if (bypass) begin
            out_ptr <= add_empty_ptr_i;
            out_val <= 1'b1;
        end else if (ack_valid) begin
            out_val <= 1'b0;
        end
    end

    // Total pointer count across RAM, in-flight read and output register.
    always_ff @(posedge clk_i) begin
        if (clear) begin
            used <= '0;
        end else begin
            unique case ({add_accept, ack_valid})
                2'b10:   used <= used + CNT_ONE;
                2'b01:   used <= used - CNT_ONE;
                default: used <= used;
            endcase
        end
    end

    // Sticky error flags; only a clear brings them back down.
    always_ff @(posedge clk_i) begin
        if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (add_drop) begin
                overflow <= 1'b1;
            end
            if (next_empty_ptr_rd_ack_i && !out_val) begin
                underflow <= 1'b1;
            end
        end
    end

    assign next_empty_ptr_o     = out_ptr;
    assign next_empty_ptr_val_o = out_val;
    assign used_o               = used;
    assign overflow_o           = overflow;
    assign underflow_o          = underflow;

endmodule : empty_ptr_storage

// File: tb/tb_empty_ptr_storage.sv
// Directed bench for the free-pointer list. The driver pushes every accepted
// pointer into a scoreboard queue; a monitor on the falling edge pops and
// compares whenever the consumer takes a pointer, and tracks used/flags
// against a small reference model every cycle.
module tb_empty_ptr_storage;

    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          srst_i;
    logic [AW-1:0] add_empty_ptr_i;
    logic          add_empty_ptr_en_i;
    logic [AW-1:0] next_empty_ptr_o;
    logic          next_empty_ptr_val_o;
    logic          next_empty_ptr_rd_ack_i;
    logic [AW:0]   used_o;
    logic          overflow_o;
    logic          underflow_o;

    // Bench's own view of whether the ack it drives is meant to be valid.
    logic          ack_ev;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [AW-1:0] sb[$];
    int            m_used = 0;
    logic          m_ovf  = 1'b0;
    logic          m_udf  = 1'b0;
    logic [AW-1:0] last_pop = '0;

    empty_ptr_storage #(
        .A_WIDTH (AW)
    ) dut (
        .clk_i                   (clk_i),
        .rst_n_i                 (rst_n_i),
        .srst_i                  (srst_i),
        .add_empty_ptr_i         (add_empty_ptr_i),
        .add_empty_ptr_en_i      (add_empty_ptr_en_i),
        .next_empty_ptr_o        (next_empty_ptr_o),
        .next_empty_ptr_val_o    (next_empty_ptr_val_o),
        .next_empty_ptr_rd_ack_i (next_empty_ptr_rd_ack_i),
        .used_o                  (used_o),
        .overflow_o              (overflow_o),
        .underflow_o             (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: updated on the same edge the DUT samples its inputs.
    always @(posedge clk_i) begin
        if (!rst_n_i || srst_i) begin
            m_used = 0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            sb.delete();
        end else begin
            logic vack;
            logic acc;
            vack = next_empty_ptr_rd_ack_i && ack_ev;
            acc  = add_empty_ptr_en_i && ((m_used < DEPTH) || vack);
            if (add_empty_ptr_en_i && !acc) m_ovf = 1'b1;
            if (next_empty_ptr_rd_ack_i && !ack_ev) m_udf = 1'b1;
            if (acc) sb.push_back(add_empty_ptr_i);
            m_used = m_used + (acc ? 1 : 0) - (vack ? 1 : 0);
        end
    end

    // Monitor: compares the handed-out pointer and the per-cycle status.
    always @(negedge clk_i) begin
        check("used", 32'(used_o), 32'(m_used));
        check("overflow", 32'(overflow_o), 32'(m_ovf));
        check("underflow", 32'(underflow_o), 32'(m_udf));
        if (m_used == 0) check("val_when_empty", 32'(next_empty_ptr_val_o), 32'd0);
        if (next_empty_ptr_val_o && next_empty_ptr_rd_ack_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ptr: got %0d with nothing expected (t=%0t)",
                         next_empty_ptr_o, $time);
            end else begin
                last_pop = sb.pop_front();
                check("ptr_order", 32'(next_empty_ptr_o), 32'(last_pop));
            end
        end
    end

    task automatic add(input logic [AW-1:0] v);
        add_empty_ptr_en_i = 1'b1;
        add_empty_ptr_i    = v;
        step();
        add_empty_ptr_en_i = 1'b0;
    endtask

    task automatic wait_val(input int max_cycles);
        int n = 0;
        while (!next_empty_ptr_val_o && n < max_cycles) begin
            step();
            n++;
        end
        check("wait_val", 32'(next_empty_ptr_val_o), 32'd1);
    endtask

    // Take k pointers, checking the bubble after each RAM-sourced refill.
    task automatic drain_n(input int k);
        for (int j = 0; j < k; j++) begin
            wait_val(20);
            next_empty_ptr_rd_ack_i = 1'b1;
            ack_ev                  = 1'b1;
            step();
            next_empty_ptr_rd_ack_i = 1'b0;
            ack_ev                  = 1'b0;
            check("bubble_val", 32'(next_empty_ptr_val_o), 32'd0);
            if (m_used > 0) begin
                step();
                check("refill_val", 32'(next_empty_ptr_val_o), 32'd1);
            end
        end
    endtask

    task automatic srst_pulse();
        srst_i = 1'b1;
        step();
        srst_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] v;
        rst_n_i                 = 1'b0;
        srst_i                  = 1'b0;
        add_empty_ptr_i         = '0;
        add_empty_ptr_en_i      = 1'b0;
        next_empty_ptr_rd_ack_i = 1'b0;
        ack_ev                  = 1'b0;
        step();
        step();
        check("rst_val", 32'(next_empty_ptr_val_o), 32'd0);
        check("rst_ptr", 32'(next_empty_ptr_o), 32'd0);
        check("rst_used", 32'(used_o), 32'd0);
        rst_n_i = 1'b1;
        step();

        // Fill then drain in order
        srst_pulse();
        for (int i = 0; i < DEPTH; i++) begin
            add(AW'(i));
            if (i == 0) begin
                check("bypass_val", 32'(next_empty_ptr_val_o), 32'd1);
                check("bypass_ptr", 32'(next_empty_ptr_o), 32'd0);
            end
        end
        check("fill_used", 32'(used_o), 32'(DEPTH));
        check("fill_ovf", 32'(overflow_o), 32'd0);
        drain_n(m_used);
        step();
        check("drained_val", 32'(next_empty_ptr_val_o), 32'd0);
        check("drain_last", 32'(last_pop), 32'(DEPTH - 1));

        // Overflow: drop when full, accept add+ack when full
        srst_pulse();
        for (int i = 0; i < DEPTH; i++) add(AW'(i));
        add(AW'(5));
        check("ovf_set", 32'(overflow_o), 32'd1);
        check("ovf_used", 32'(used_o), 32'(DEPTH));
        wait_val(20);
        add_empty_ptr_en_i      = 1'b1;
        add_empty_ptr_i         = AW'(6);
        next_empty_ptr_rd_ack_i = 1'b1;
        ack_ev                  = 1'b1;
        step();
        add_empty_ptr_en_i      = 1'b0;
        next_empty_ptr_rd_ack_i = 1'b0;
        ack_ev                  = 1'b0;
        check("full_addack_used", 32'(used_o), 32'(DEPTH));
        drain_n(m_used);
        check("ovf_last", 32'(last_pop), 32'd6);

        // Underflow and bypass paths
        srst_pulse();
        next_empty_ptr_rd_ack_i = 1'b1;
        step();
        next_empty_ptr_rd_ack_i = 1'b0;
        check("udf_set", 32'(underflow_o), 32'd1);
        add(AW'(3));
        check("byp3_val", 32'(next_empty_ptr_val_o), 32'd1);
        check("byp3_ptr", 32'(next_empty_ptr_o), 32'd3);
        add_empty_ptr_en_i      = 1'b1;
        add_empty_ptr_i         = AW'(4);
        next_empty_ptr_rd_ack_i = 1'b1;
        ack_ev                  = 1'b1;
        step();
        add_empty_ptr_en_i      = 1'b0;
        next_empty_ptr_rd_ack_i = 1'b0;
        ack_ev                  = 1'b0;
        check("noback_val", 32'(next_empty_ptr_val_o), 32'd1);
        check("noback_ptr", 32'(next_empty_ptr_o), 32'd4);
        drain_n(m_used);

        // Wrap-around: three rounds of fill, half drain, half refill
        srst_pulse();
        v = '0;
        for (int r = 0; r < 3; r++) begin
            int n;
            n = DEPTH - m_used;
            for (int i = 0; i < n; i++) begin
                add(v);
                v = v + AW'(3);
            end
            check("wrap_full", 32'(used_o), 32'(DEPTH));
            drain_n(DEPTH / 2);
            for (int i = 0; i < DEPTH / 2; i++) begin
                add(v);
                v = v + AW'(3);
            end
        end
        drain_n(m_used);

        // srst with add and ack while half full
        srst_pulse();
        next_empty_ptr_rd_ack_i = 1'b1;
        step();
        next_empty_ptr_rd_ack_i = 1'b0;
        add(AW'(0)); add(AW'(1)); add(AW'(2)); add(AW'(4));
        wait_val(20);
        srst_i                  = 1'b1;
        add_empty_ptr_en_i      = 1'b1;
        add_empty_ptr_i         = AW'(7);
        next_empty_ptr_rd_ack_i = 1'b1;
        ack_ev                  = 1'b1;
        step();
        srst_i                  = 1'b0;
        add_empty_ptr_en_i      = 1'b0;
        next_empty_ptr_rd_ack_i = 1'b0;
        ack_ev                  = 1'b0;
        check("srst_used", 32'(used_o), 32'd0);
        check("srst_val", 32'(next_empty_ptr_val_o), 32'd0);
        check("srst_udf", 32'(underflow_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("srst_idle_val", 32'(next_empty_ptr_val_o), 32'd0);
        end
        add(AW'(2));
        check("post_srst_ptr", 32'(next_empty_ptr_o), 32'd2);
        drain_n(m_used);

        // rst_n_i low while a refill read is in flight
        add(AW'(0)); add(AW'(1)); add(AW'(2)); add(AW'(4));
        wait_val(20);
        next_empty_ptr_rd_ack_i = 1'b1;
        ack_ev                  = 1'b1;
        step();
        next_empty_ptr_rd_ack_i = 1'b0;
        ack_ev                  = 1'b0;
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        check("rst_mid_val", 32'(next_empty_ptr_val_o), 32'd0);
        check("rst_mid_used", 32'(used_o), 32'd0);
        check("rst_mid_ptr", 32'(next_empty_ptr_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_idle_val", 32'(next_empty_ptr_val_o), 32'd0);
        end
        add(AW'(5));
        check("post_rst_ptr", 32'(next_empty_ptr_o), 32'd5);
        drain_n(m_used);
        step();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_empty_ptr_storage

// File: doc/empty_ptr_storage.md
# empty_ptr_storage

Free-list of data-table pointers for the hash table. It receives the pointer stream produced by the table initializer (cleared by its storage-reset pulse) and pointers returned by delete logic, and it hands one free pointer at a time to the insert engine through a show-ahead valid/ack port. Storage is a 2^A_WIDTH-deep RAM FIFO with a single output register.

## Interface
Parameters:
- A_WIDTH, default TABLE_ADDR_WIDTH: data-table pointer width; capacity is 2^A_WIDTH pointers.

Ports:
- clk_i  input  1  sole clock.
- rst_n_i  input  1  reset; synchronous, active-low.
- srst_i  input  1  synchronous clear pulse from the initializer; empties storage.
- add_empty_ptr_i  input  A_WIDTH  pointer to store.
- add_empty_ptr_en_i  input  1  store strobe; one pointer per cycle.
- next_empty_ptr_o  output  A_WIDTH  head pointer; meaningful only while valid.
- next_empty_ptr_val_o  output  1  head pointer available.
- next_empty_ptr_rd_ack_i  input  1  consumer takes the head pointer this cycle.
- used_o  output  A_WIDTH+1  pointers held: RAM, in-flight read and output register.
- overflow_o  output  1  sticky; an add was dropped because storage was full.
- underflow_o  output  1  sticky; an ack arrived while val was low.

## Operation
- Reset (rst_n_i low at a clock edge):
  - all outputs go to 0;
  - RAM pointers clear;
  - any in-flight read is cancelled.
- srst_i has the same effect as reset, including clearing both sticky flags. srst_i overrides add/ack in the same cycle; an add on that cycle is dropped without setting overflow_o.
- Pointers leave in FIFO order, exactly as added.
- Add path:
  - Bypass into the output register when all three hold: RAM empty, no read in flight, and (output register empty or being acked this cycle).
  - Otherwise write at wr_ptr and increment wr_ptr.
- Refill: when the output register is empty or acked, and the RAM is non-empty, and no read is in flight, issue a RAM read at rd_ptr and increment rd_ptr. The data loads into the output register on the next cycle.
- Full: used_o == 2^A_WIDTH. An add while full and not acked in the same cycle is dropped and sets overflow_o. Add and ack in the same cycle while full is accepted.
- Ack while next_empty_ptr_val_o is low is ignored and sets underflow_o.
- used_o:
  - +1 per accepted add;
  - -1 per valid ack;
  - unchanged when both occur.
- RAM wr_ptr and rd_ptr are A_WIDTH bits and wrap modulo 2^A_WIDTH. RAM empty/full is derived from an A_WIDTH+1 RAM occupancy counter, never from pointer equality alone.
- Simultaneous RAM write and read to the same address cannot occur, because a read is issued only while RAM is non-empty.

## Timing
- Bypass latency: add at cycle N with storage empty gives val high at N+1 with that pointer.
- Ack at N with RAM non-empty: val low at N+1, high at N+2 with the next pointer (one-cycle bubble).
- Ack at N with RAM empty but a bypass add at N: next pointer valid at N+1, no bubble.
- Ack at N with nothing else held: val low from N+1.
- used_o, overflow_o and underflow_o update on the edge following the event.
- RAM read latency is exactly one cycle, registered address, no output register.
- Reset or srst_i at N: val low and used_o = 0 from N+1.

## Structure
- Shared package hash_table holds TABLE_ADDR_WIDTH; no new typedefs are needed.
- One sub-module: empty_ptr_ram, a simple dual-port RAM of 2^A_WIDTH x A_WIDTH with one write port, one read port and 1-cycle registered read.
- Control (pointers, occupancy counters, read-in-flight flag, output register, sticky flags) lives in empty_ptr_storage.

## Test plan
- Fill: srst_i pulse, then add 0..2^A_WIDTH-1 back-to-back -> used_o = 2^A_WIDTH, val high with ptr 0 from the cycle after the first add, overflow_o stays 0.
- Drain: ack every cycle val is high -> pointers 0,1,2,… in order, each RAM-sourced pointer after one bubble cycle, used_o reaches 0, then val low.
- Overflow: from full, add 0x5 without ack -> dropped, overflow_o = 1, used_o unchanged. Add 0x6 with ack same cycle -> accepted, 0x6 emerges last.
- Underflow/bypass: empty storage, ack -> underflow_o = 1. Add 0x3 with storage empty -> val high with 0x3 next cycle.
- Wrap-around: 3 x (fill 2^A_WIDTH, drain half, add half new values) -> FIFO order preserved across pointer wrap, used_o exact every cycle against a reference model.
- Mid-operation clears: srst_i together with add 0x7 and ack while half full -> next cycle used_o = 0, val low, 0x7 absent, flags cleared. Repeat with rst_n_i low mid-refill -> same result, no stale pointer appears.
